// File: rtl/rf_ctrl_pkg.sv
// Shared register-file control package: default widths and the clogb2
// address-width helper used by the RF port arbiters.
package rf_ctrl_pkg;

   localparam int RF_DATA_W = 32;
   localparam int RF_DEPTH  = 16;

   // Number of bits needed to index 'value' entries, never less than one.
   function automatic int clogb2(input int value);
      int r;
      r = 0;
      while ((1 << r) < value) begin
         r = r + 1;
      end
      if (r < 1) begin
         r = 1;
      end else begin
         r = r;
      end
      return r;
   endfunction

endpackage

// File: rtl/rf_wr_port_arbiter_if.sv
// Bus bundle of the RF write-port arbiter: requester handshakes, global lock
// and the register-file write port. The pending_out vector exists only when
// RF_WR_ARB_PENDING_EN is defined.
interface rf_wr_port_arbiter_if #(
   parameter int data_width_g = rf_ctrl_pkg::RF_DATA_W,
   parameter int depth_g      = rf_ctrl_pkg::RF_DEPTH,
   parameter int num_req_g    = 4
);
   import rf_ctrl_pkg::*;

   localparam int AW = clogb2(depth_g);

   logic                              glock_in;
   logic [num_req_g-1:0]              req_valid_in;
   logic [num_req_g-1:0]              req_ready_out;
   logic [num_req_g*data_width_g-1:0] req_data_in;
   logic [num_req_g*AW-1:0]           req_addr_in;
   logic                              wload_out;
   logic [data_width_g-1:0]           wdata_out;
   logic [AW-1:0]                     wop_out;
   logic [num_req_g-1:0]              grant_out;
   logic                              busy_out;
`ifdef RF_WR_ARB_PENDING_EN
   logic [depth_g-1:0]                pending_out;
`endif

   // Arbiter side.
   modport slave (
      input  glock_in, req_valid_in, req_data_in, req_addr_in,
      output req_ready_out, wload_out, wdata_out, wop_out, grant_out, busy_out
`ifdef RF_WR_ARB_PENDING_EN
      , output pending_out
`endif
   );

   // Requester / register-file side.
   modport master (
      output glock_in, req_valid_in, req_data_in, req_addr_in,
      input  req_ready_out, wload_out, wdata_out, wop_out, grant_out, busy_out
`ifdef RF_WR_ARB_PENDING_EN
      , input pending_out
`endif
   );

endinterface

// File: rtl/rr_arbiter_onehot.sv
// Round-robin arbiter with one-hot winner. The search starts at the internal
// pointer; on 'advance' the pointer moves to the slot after the winner.
module rr_arbiter_onehot #(
   parameter int n = 4
) (
   input  logic         clk,
   input  logic         rstx,
   input  logic [n-1:0] req,
   input  logic         advance,
   output logic [n-1:0] win
);
   import rf_ctrl_pkg::*;

   localparam int PW = clogb2(n);
   localparam logic [n-1:0] ONE = {{(n-1){1'b0}}, 1'b1};

   logic [PW-1:0] ptr_r;
   logic [PW-1:0] ptr_next_s;
   logic [PW-1:0] win_idx_s;
   logic [n-1:0]  win_s;
   logic [n-1:0]  sel_s;
   logic          found_s;
   logic          hit_s;
   int            idx_s;

   // Scan from the pointer upward with wrap; the first requesting slot wins.
   always_comb begin
      win_s     = '0;
      win_idx_s = '0;
      found_s   = 1'b0;
      hit_s     = 1'b0;
      sel_s     = '0;
      idx_s     = 0;
      for (int k = 0; k < n; k++) begin
         idx_s     = int'(ptr_r) + k;
         idx_s     = (idx_s >= n) ? idx_s - n : idx_s;
         sel_s     = ONE << idx_s;
         hit_s     = (|(req & sel_s)) & ~found_s;
         win_s     = win_s | (hit_s ? sel_s : '0);
         win_idx_s = hit_s ? idx_s[PW-1:0] : win_idx_s;
         found_s   = found_s | hit_s;
      end
   end

   // Next pointer is the slot after the winner, wrapping from n-1 to 0.
   always_comb begin
      ptr_next_s = (win_idx_s == PW'(n - 1)) ? '0 : win_idx_s + PW'(1);
   end

   // Pointer register: moves only when a grant is actually taken.
   always_ff @(posedge clk or negedge rstx) begin
      if (!rstx) begin
         ptr_r <= '0;
      end else if (advance) begin
         ptr_r <= ptr_next_s;
      end
   end

   assign win = win_s;

endmodule

// File: rtl/rf_wr_port_arbiter.sv
// Shares the single write port of a 1W/1R guarded register file between
// num_req_g requesters. Round-robin arbitration, one registered output stage
// driving wload/wdata/wop, and glock handling so no write is lost while the
// RF ignores wload. Optional: RF_WR_ARB_PENDING_EN adds pending_out, a
// per-register in-flight-write vector for read-side stalling.
module rf_wr_port_arbiter #(
   parameter int data_width_g = rf_ctrl_pkg::RF_DATA_W,
   parameter int depth_g      = rf_ctrl_pkg::RF_DEPTH,
   parameter int num_req_g    = 4
) (
   input logic                 clk,
   input logic                 rstx,
   rf_wr_port_arbiter_if.slave bus
);
   import rf_ctrl_pkg::*;

   localparam int AW = clogb2(depth_g);

   logic                    out_valid_r;
   logic [data_width_g-1:0] data_r;
   logic [AW-1:0]           addr_r;
   logic [num_req_g-1:0]    grant_r;

   logic [num_req_g-1:0]    win_s;
   logic                    can_accept_s;
   logic                    accept_s;
   logic                    retire_s;
   logic [data_width_g-1:0] sel_data_s;
   logic [AW-1:0]           sel_addr_s;

   rr_arbiter_onehot #(.n(num_req_g)) u_rr (
      .clk     (clk),
      .rstx    (rstx),
      .req     (bus.req_valid_in),
      .advance (accept_s),
      .win     (win_s)
   );

   // Stage can take a new write when empty or when its write commits this edge.
   always_comb begin
      can_accept_s = ~out_valid_r | ~bus.glock_in;
      accept_s     = can_accept_s & (|bus.req_valid_in);
      retire_s     = out_valid_r & ~bus.glock_in;
   end

   // One-hot mux of the winner's data and register index.
   always_comb begin
      sel_data_s = '0;
      sel_addr_s = '0;
      for (int i = 0; i < num_req_g; i++) begin
         sel_data_s = sel_data_s |
            ({data_width_g{win_s[i]}} & bus.req_data_in[i*data_width_g +: data_width_g]);
         sel_addr_s = sel_addr_s | ({AW{win_s[i]}} & bus.req_addr_in[i*AW +: AW]);
      end
   end

   // Output stage: load on accept, drop valid on retire, otherwise hold.
   always_ff @(posedge clk or negedge rstx) begin
      if (!rstx) begin
         out_valid_r <= 1'b0;
         data_r      <= '0;
         addr_r      <= '0;
         grant_r     <= '0;
      end else if (accept_s) begin
         out_valid_r <= 1'b1;
         data_r      <= sel_data_s;
         addr_r      <= sel_addr_s;
         grant_r     <= win_s;
      end else if (retire_s) begin
         out_valid_r <= 1'b0;
      end
   end

   assign bus.req_ready_out = win_s & {num_req_g{can_accept_s}};
   assign bus.wload_out     = out_valid_r;
   assign bus.busy_out      = out_valid_r;
   assign bus.wdata_out     = data_r;
   assign bus.wop_out       = addr_r;
   assign bus.grant_out     = grant_r;

`ifdef RF_WR_ARB_PENDING_EN
   logic [depth_g-1:0] pending_s;

   // Decode the in-flight register index, qualified by the stage valid.
   always_comb begin
      pending_s = '0;
      for (int k = 0; k < depth_g; k++) begin
         pending_s[k] = out_valid_r & (addr_r == AW'(k));
      end
   end

   assign bus.pending_out = pending_s;
`endif

endmodule

// File: tb/tb_rf_wr_port_arbiter.sv
// Self-checking bench for rf_wr_port_arbiter: a vector table from reset,
// hand-written corner sequences and a randomized run against a reference
// model built from the arbitration rules.
module tb_rf_wr_port_arbiter;
   import rf_ctrl_pkg::*;

   localparam int W  = 32;
   localparam int D  = 16;
   localparam int N  = 4;
   localparam int AW = clogb2(D);
   localparam logic [N-1:0] ONE = {{(N-1){1'b0}}, 1'b1};

   logic clk = 1'b0;
   logic rstx;

   always #5 clk = ~clk;

   rf_wr_port_arbiter_if #(.data_width_g(W), .depth_g(D), .num_req_g(N)) bus ();

   rf_wr_port_arbiter #(.data_width_g(W), .depth_g(D), .num_req_g(N)) dut (
      .clk  (clk),
      .rstx (rstx),
      .bus  (bus)
   );

   int checks = 0;
   int errors = 0;

   logic [W-1:0]  d_in [N];
   logic [AW-1:0] a_in [N];
   logic [N-1:0]  cur_v;
   logic          cur_gl;

   // reference model state
   int            m_ptr;
   logic          m_v;
   logic [W-1:0]  m_data;
   logic [AW-1:0] m_addr;
   logic [N-1:0]  m_grant;

   typedef struct {
      logic [N-1:0] v;
      logic         gl;
      logic [N-1:0] ready;
      logic         wload;
      logic [N-1:0] grant;
   } vec_t;

   vec_t tbl [10];

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic drive(input logic [N-1:0] v, input logic gl);
      cur_v  = v;
      cur_gl = gl;
      bus.req_valid_in = v;
      bus.glock_in     = gl;
      for (int i = 0; i < N; i++) begin
         bus.req_data_in[i*W +: W]   = d_in[i];
         bus.req_addr_in[i*AW +: AW] = a_in[i];
      end
   endtask

   task automatic model_reset();
      m_ptr   = 0;
      m_v     = 1'b0;
      m_data  = '0;
      m_addr  = '0;
      m_grant = '0;
   endtask

   // Winner under the rules: none while a locked write is held, else the
   // first valid requester at or after the pointer.
   function automatic int m_winner();
      if (m_v && cur_gl) return -1;
      for (int k = 0; k < N; k++) begin
         int i;
         i = (m_ptr + k) % N;
         if (cur_v[i]) return i;
      end
      return -1;
   endfunction

   task automatic check_outputs(input string tag);
      chk({tag, " wload"}, 64'(bus.wload_out), 64'(m_v));
      chk({tag, " busy"},  64'(bus.busy_out),  64'(m_v));
      chk({tag, " wdata"}, 64'(bus.wdata_out), 64'(m_data));
      chk({tag, " wop"},   64'(bus.wop_out),   64'(m_addr));
      chk({tag, " grant"}, 64'(bus.grant_out), 64'(m_grant));
`ifdef RF_WR_ARB_PENDING_EN
      chk({tag, " pending"}, 64'(bus.pending_out), m_v ? (64'd1 << m_addr) : 64'd0);
`endif
   endtask

   // One clock cycle with the currently driven inputs, checked against the model.
   task automatic step(input string tag);
      int w;
      logic [N-1:0] er;
      #1;
      w  = m_winner();
      er = (w >= 0) ? (ONE << w) : '0;
      chk({tag, " ready"}, 64'(bus.req_ready_out), 64'(er));
      @(posedge clk);
      if (w >= 0) begin
         m_v     = 1'b1;
         m_data  = d_in[w];
         m_addr  = a_in[w];
         m_grant = ONE << w;
         m_ptr   = (w + 1) % N;
      end else if (m_v && !cur_gl) begin
         m_v = 1'b0;
      end
      #1;
      check_outputs(tag);
   endtask

   // Asynchronous reset from any state; outputs must clear immediately.
   task automatic do_reset(input string tag);
      rstx = 1'b0;
      #1;
      chk({tag, " rst wload"}, 64'(bus.wload_out), 64'd0);
      chk({tag, " rst busy"},  64'(bus.busy_out),  64'd0);
      chk({tag, " rst wdata"}, 64'(bus.wdata_out), 64'd0);
      chk({tag, " rst wop"},   64'(bus.wop_out),   64'd0);
      chk({tag, " rst grant"}, 64'(bus.grant_out), 64'd0);
`ifdef RF_WR_ARB_PENDING_EN
      chk({tag, " rst pending"}, 64'(bus.pending_out), 64'd0);
`endif
      drive('0, 1'b0);
      #1;
      chk({tag, " rst ready"}, 64'(bus.req_ready_out), 64'd0);
      @(posedge clk);
      #1;
      rstx = 1'b1;
      model_reset();
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not complete in time");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [31:0] rv;

      // state sequence from reset: ptr=0, stage empty
      tbl[0] = '{4'b0000, 1'b0, 4'b0000, 1'b0, 4'b0000};
      tbl[1] = '{4'b0110, 1'b0, 4'b0010, 1'b1, 4'b0010};
      tbl[2] = '{4'b0011, 1'b0, 4'b0001, 1'b1, 4'b0001};
      tbl[3] = '{4'b1111, 1'b1, 4'b0000, 1'b1, 4'b0001};
      tbl[4] = '{4'b1010, 1'b0, 4'b0010, 1'b1, 4'b0010};
      tbl[5] = '{4'b0000, 1'b0, 4'b0000, 1'b0, 4'b0010};
      tbl[6] = '{4'b0001, 1'b1, 4'b0001, 1'b1, 4'b0001};
      tbl[7] = '{4'b1000, 1'b1, 4'b0000, 1'b1, 4'b0001};
      tbl[8] = '{4'b1000, 1'b0, 4'b1000, 1'b1, 4'b1000};
      tbl[9] = '{4'b0000, 1'b0, 4'b0000, 1'b0, 4'b1000};

      for (int i = 0; i < N; i++) begin
         d_in[i] = 32'h1000_0000 + 32'(i);
         a_in[i] = AW'(i);
      end
      rstx = 1'b1;
      drive('0, 1'b0);
      model_reset();
      #2;
      do_reset("por");

      // vector table
      for (int e = 0; e < 10; e++) begin
         drive(tbl[e].v, tbl[e].gl);
         #1;
         chk($sformatf("tbl%0d ready", e), 64'(bus.req_ready_out), 64'(tbl[e].ready));
         @(posedge clk);
         #1;
         chk($sformatf("tbl%0d wload", e), 64'(bus.wload_out), 64'(tbl[e].wload));
         chk($sformatf("tbl%0d grant", e), 64'(bus.grant_out), 64'(tbl[e].grant));
      end

      // single write
      do_reset("single");
      d_in[0] = 32'hA5A5_A5A5;
      a_in[0] = AW'(3);
      drive(4'b0001, 1'b0);
      #1;
      chk("single ready0", 64'(bus.req_ready_out), 64'h1);
      step("single");
      chk("single wload1", 64'(bus.wload_out), 64'd1);
      chk("single wop",    64'(bus.wop_out),   64'd3);
      chk("single wdata",  64'(bus.wdata_out), 64'hA5A5_A5A5);
      chk("single grant",  64'(bus.grant_out), 64'h1);
      drive('0, 1'b0);
      step("single_idle");
      chk("single wload0", 64'(bus.wload_out), 64'd0);

      // rotation with all requesters valid
      do_reset("rot");
      drive(4'b1111, 1'b0);
      for (int k = 0; k < 6; k++) begin
         step("rot");
         chk($sformatf("rot%0d grant", k), 64'(bus.grant_out), 64'(ONE << (k % N)));
         chk($sformatf("rot%0d wload", k), 64'(bus.wload_out), 64'd1);
      end

      // lock stall
      do_reset("lock");
      drive(4'b0010, 1'b0);
      step("lock_acc");
      for (int k = 0; k < 3; k++) begin
         drive(4'b0100, 1'b1);
         #1;
         chk("lock ready2", 64'(bus.req_ready_out), 64'd0);
         step("lock_hold");
         chk("lock wload", 64'(bus.wload_out), 64'd1);
         chk("lock wop",   64'(bus.wop_out),   64'(a_in[1]));
         chk("lock wdata", 64'(bus.wdata_out), 64'(d_in[1]));
      end
      drive(4'b0100, 1'b0);
      #1;
      chk("lock release ready", 64'(bus.req_ready_out), 64'h4);
      step("lock_release");
      chk("lock release grant", 64'(bus.grant_out), 64'h4);
      chk("lock release wdata", 64'(bus.wdata_out), 64'(d_in[2]));
      chk("lock release wload", 64'(bus.wload_out), 64'd1);

      // pointer fairness
      do_reset("fair");
      drive(4'b0010, 1'b0);
      step("fair_req1");
      drive(4'b1001, 1'b0);
      step("fair_a");
      chk("fair first req3", 64'(bus.grant_out), 64'h8);
      step("fair_b");
      chk("fair then req0", 64'(bus.grant_out), 64'h1);

      // reset mid-operation
      do_reset("mid_pre");
      drive(4'b0001, 1'b0);
      step("mid_acc");
      chk("mid busy before", 64'(bus.busy_out), 64'd1);
      do_reset("mid");
      for (int k = 0; k < 3; k++) begin
         step("mid_idle");
         chk("mid idle wload", 64'(bus.wload_out), 64'd0);
      end
      drive(4'b0110, 1'b0);
      #1;
      chk("mid lowest ready", 64'(bus.req_ready_out), 64'h2);
      step("mid_first");
      chk("mid lowest grant", 64'(bus.grant_out), 64'h2);

`ifdef RF_WR_ARB_PENDING_EN
      // pending vector
      do_reset("pend");
      a_in[0] = AW'(5);
      drive(4'b0001, 1'b0);
      step("pend_acc");
      drive('0, 1'b1);
      step("pend_lock");
      chk("pend held", 64'(bus.pending_out), 64'h20);
      step("pend_lock2");
      chk("pend held2", 64'(bus.pending_out), 64'h20);
      drive('0, 1'b0);
      step("pend_retire");
      chk("pend clear", 64'(bus.pending_out), 64'd0);
`endif

      // randomized traffic against the model
      do_reset("rnd");
      for (int c = 0; c < 400; c++) begin
         for (int i = 0; i < N; i++) begin
            d_in[i] = $urandom();
            rv      = $urandom_range(0, D - 1);
            a_in[i] = rv[AW-1:0];
         end
         rv = $urandom();
         drive(rv[N-1:0], ($urandom_range(0, 3) == 0));
         step("rnd");
      end

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/rf_wr_port_arbiter.md
Name: rf_wr_port_arbiter

Overview:
- Shares the single write port of a 1-write/1-read guarded register file between num_req_g requesters, such as FU result buses or load-return paths.
- Round-robin arbitration with valid/ready handshake on each requester.
- One registered output stage drives wload/wdata/wop of the register file directly.
- Honours the global lock so that no write is lost while the RF ignores writes.

Parameters:
- data_width_g, 32, width of write data.
- depth_g, 16, number of RF registers; address width AW = clogb2(depth_g), minimum 1.
- num_req_g, 4, number of write requesters, 2..8.

Ports:
- clk  in  1  clock
- rstx  in  1  reset
- glock_in  in  1  global lock; RF ignores wload while high
- req_valid_in  in  num_req_g  per-requester write request
- req_ready_out  out  num_req_g  per-requester accept; transfer when valid&ready
- req_data_in  in  num_req_g*data_width_g  packed data, requester i at bits [i*W +: W]
- req_addr_in  in  num_req_g*AW  packed register index, requester i at bits [i*AW +: AW]
- wload_out  out  1  to RF wload
- wdata_out  out  data_width_g  to RF wdata
- wop_out  out  AW  to RF wop
- grant_out  out  num_req_g  one-hot index of the requester held in the output stage
- busy_out  out  1  output stage holds a write

Behaviour:
- Reset: rstx is asynchronous, active-low; clock is clk. Reset clears:
  - wload_out=0, wdata_out=0, wop_out=0, grant_out=0, busy_out=0.
  - Round-robin pointer = 0.
  - req_ready_out=0 combinationally while no request is valid.
- Output stage, one register set: out_valid, data, addr, grant.
  - wload_out = out_valid. busy_out = out_valid.
- Retire: the stage retires on a cycle where out_valid=1 and glock_in=0, because the RF commits the write on that edge.
- Accept condition: can_accept = ~out_valid | ~glock_in.
- Arbitration is combinational.
  - Starting at the pointer, the first i with req_valid_in[i]=1 wins.
  - req_ready_out[i] = win[i] & can_accept.
  - ready may depend on valid, and only the winner sees ready.
- On the accept edge:
  - The stage loads the winner's data/addr/grant and sets out_valid=1.
  - The pointer moves to (winner+1) mod num_req_g.
  - With no accept, the pointer holds.
- Retire and accept in the same cycle give back-to-back writes: one write per cycle, no bubble.
- If the stage retires with no new accept, out_valid goes to 0 and data/addr/grant hold their values (don't-care).
- glock_in high with out_valid=1: all outputs hold, and every ready is 0.
- glock_in high with out_valid=0: one request may be accepted, then the stage holds.
- Latency: a request accepted at edge N has wload_out=1 during cycle N+1. The RF commits at edge N+1 if unlocked.
- Same-address writes from two requesters are serialised in grant order, so the later grant wins in the RF. No merging.
- A requester must hold valid/data/addr stable until ready. Dropping valid before ready is allowed; that request is simply not granted.
- Reset mid-operation discards the in-flight write, with no RF write afterwards, and the pointer returns to 0.
- Pointer wrap: (num_req_g-1)+1 gives 0.

Optional Feature:
- Macro RF_WR_ARB_PENDING_EN.
- Defined: adds the output pending_out [depth_g-1:0].
  - pending_out[k] = out_valid & (addr==k).
  - Read-side logic uses it to stall reads of a register, or of its guard bit, whose write is still in flight.
  - It updates in the same cycle as out_valid.
- Undefined: the port and its logic are absent, and behaviour is otherwise identical.

Decomposition:
- Shared package rf_ctrl_pkg:
  - clogb2 function.
  - Default width constants: RF_DATA_W=32, RF_DEPTH=16.
- Sub-module rr_arbiter_onehot (parameter n):
  - Inputs: req, ptr, advance. Outputs: one-hot win, next-pointer register.
  - Reused by future read-port arbiters.
- Top module: output stage, handshake, pending logic.

Test Plan:
- Single write: only req0 valid, addr=3, data=0xA5A5A5A5, glock=0.
  - Same cycle: ready0=1.
  - Next cycle: wload_out=1, wop_out=3, wdata_out=0xA5A5A5A5, grant_out=0001.
  - Cycle after: wload_out=0.
- Rotation: all four requests held valid continuously.
  - Grants in consecutive cycles are 0,1,2,3,0,1.
  - wload_out stays 1 every cycle.
- Lock stall: req1 accepted, then glock_in=1 for 3 cycles with req2 valid.
  - wload_out/wop_out/wdata_out hold the req1 values.
  - ready2=0 throughout.
  - glock falls: req1 retires and req2 is accepted the same cycle; req2 appears on wload next cycle.
- Pointer fairness: pointer=2 after a grant to req1, with req0 and req3 valid.
  - req3 is granted first, then req0.
- Reset mid-op: assert rstx=0 while out_valid=1.
  - All outputs 0 immediately (asynchronous).
  - After release with no requests, wload_out stays 0.
  - The first grant comes from the lowest valid index.
- RF_WR_ARB_PENDING_EN: accept a write to addr 5.
  - pending_out = 1<<5 while held under glock.
  - Returns to 0 after retire with no new accept.
